timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_if.sv | 14 +
 rtl/timer_unit.sv | 117 +++++++++++
 tb/tb_timer_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/timer_if.sv
// Register-bus bundle between the coprocessor (master) and the timer (slave).
interface timer_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;

  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_unit.sv
// 32-bit countdown timer with CTRL/PRESET/COUNT word registers and a
// maskable interrupt, in one-shot or auto-reload mode.
module timer_unit (
  input  logic    clk,
  input  logic    rst,
  timer_if.slave  bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  state_t        state, state_nxt;
  ctrl_t         ctrl;
  logic [DW-1:0] preset;
  logic [DW-1:0] count;
  logic          flag;

  logic ctrl_wr_c, preset_wr_c;
  logic load_c, dec_c, expire_c, reload_clr_c, oneshot_clr_c;
  logic auto_reload_c;

  assign ctrl_wr_c     = bus.we && (bus.addr == A_CTRL);
  assign preset_wr_c   = bus.we && (bus.addr == A_PRESET);
  assign auto_reload_c = (ctrl.mode == 2'b01);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; decisions see register values before this edge's write
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (ctrl.en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!ctrl.en)             state_nxt = ST_IDLE;
        else if (count > 32'd1)   state_nxt = ST_CNT;
        else                      state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    load_c        = 1'b0;
    dec_c         = 1'b0;
    expire_c      = 1'b0;
    reload_clr_c  = 1'b0;
    oneshot_clr_c = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_LOAD: load_c = 1'b1;
      ST_CNT: begin
        if (ctrl.en) begin
          if (count > 32'd1) dec_c    = 1'b1;
          else               expire_c = 1'b1;
        end
      end
      ST_INT: begin
        if (auto_reload_c) reload_clr_c  = 1'b1;
        else               oneshot_clr_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; a bus write to CTRL takes precedence over the one-shot EN clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      if (ctrl_wr_c)          ctrl    <= ctrl_t'(bus.din[CW-1:0]);
      else if (oneshot_clr_c) ctrl.en <= 1'b0;

      if (preset_wr_c) preset <= bus.din;

      if (load_c)        count <= preset;
      else if (dec_c)    count <= count - 32'd1;
      else if (expire_c) count <= '0;

      if (ctrl_wr_c || load_c || reload_clr_c) flag <= 1'b0;
      else if (expire_c)                        flag <= 1'b1;
    end
  end

  // Combinational read mux; unmapped word reads as zero
  always_comb begin
    bus.dout = '0;
    unique case (bus.addr)
      A_CTRL:   bus.dout = DW'(ctrl);
      A_PRESET: bus.dout = preset;
      A_COUNT:  bus.dout = count;
      default:  bus.dout = '0;
    endcase
  end

  assign bus.irq = flag & ctrl.im;
endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: one-shot, auto-reload, masking, mid-count
// control and asynchronous reset behaviour.
module tb_timer_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  timer_if bus();

  timer_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b1;
    bus.din  = d;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  initial begin
    rst      = 1'b0;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = '0;
    #2;
    rd("rst_ctrl",   2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count",  2'd2, 32'h0);
    rd("rst_unmap",  2'd3, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    #4;
    rst = 1'b1;
    tick();

    // One-shot, PRESET=5, IM set
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(); tick();
    rd("os_count0", 2'd2, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      rd($sformatf("os_count%0d", i), 2'd2, 32'(5 - i));
      chk($sformatf("os_irq%0d", i), 32'(bus.irq), (i == 5) ? 32'h1 : 32'h0);
    end
    tick();
    rd("os_ctrl_autoclr", 2'd0, 32'h8);
    chk("os_irq_hold", 32'(bus.irq), 32'h1);
    tick(); tick();
    chk("os_irq_hold2", 32'(bus.irq), 32'h1);
    rd("os_count_idle", 2'd2, 32'd0);

    // CTRL write clears the flag
    wr(2'd0, 32'h8);
    chk("clr_irq", 32'(bus.irq), 32'h0);
    tick(); tick();
    rd("clr_count", 2'd2, 32'd0);
    chk("clr_irq2", 32'(bus.irq), 32'h0);
    wr(2'd0, 32'hFFFF_FFF8);
    rd("ctrl_upper_zero", 2'd0, 32'h8);

    // Auto-reload, PRESET=3: pulses at t0+5, +11, +17
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("ar_irq_c%0d", k), 32'(bus.irq),
          32'((k >= 5) && (((k - 5) % 6) == 0)));
    end
    wr(2'd0, 32'h0);
    tick(); tick();

    // PRESET=0 expires at t0+3; then masked expiry
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    chk("p0_irq_c1", 32'(bus.irq), 32'h0);
    tick();
    chk("p0_irq_c2", 32'(bus.irq), 32'h0);
    tick();
    chk("p0_irq_c3", 32'(bus.irq), 32'h1);
    tick();
    wr(2'd0, 32'h1);
    chk("mask_clr_irq", 32'(bus.irq), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("mask_irq_c%0d", k), 32'(bus.irq), 32'h0);
    end
    rd("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("unmask_after_wr", 32'(bus.irq), 32'h0);

    // Mid-count stop at 40, then PRESET write during CNT
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 61; k++) tick();
    rd("mid_count41", 2'd2, 32'd41);
    wr(2'd0, 32'h0);
    rd("mid_count40", 2'd2, 32'd40);
    tick(); tick(); tick();
    rd("mid_frozen", 2'd2, 32'd40);
    wr(2'd0, 32'h1);
    tick(); tick();
    rd("restart_load", 2'd2, 32'd100);
    wr(2'd1, 32'd7);
    rd("preset_cnt_99", 2'd2, 32'd99);
    tick();
    rd("preset_cnt_98", 2'd2, 32'd98);
    rd("preset_new", 2'd1, 32'd7);
    for (int k = 0; k < 78; k++) tick();
    rd("pre_rst_count", 2'd2, 32'd20);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_irq", 32'(bus.irq), 32'h0);
    rd("arst_count",  2'd2, 32'h0);
    rd("arst_ctrl",   2'd0, 32'h0);
    rd("arst_preset", 2'd1, 32'h0);
    rd("arst_unmap",  2'd3, 32'h0);

    // Held COUNT write across release is ignored
    bus.addr = 2'd2;
    bus.we   = 1'b1;
    bus.din  = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.we = 1'b0;
    rd("cnt_wr_ignored", 2'd2, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("unmap_wr_ctrl", 2'd0, 32'h0);
    rd("unmap_wr_preset", 2'd1, 32'h0);

    // Held PRESET write across release lands on the first edge
    rst = 1'b0;
    bus.addr = 2'd1;
    bus.we   = 1'b1;
    bus.din  = 32'h55;
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.we = 1'b0;
    rd("rel_preset_wr", 2'd1, 32'h55);
    for (int k = 0; k < 5; k++) tick();
    rd("rel_idle_count", 2'd2, 32'h0);
    chk("rel_idle_irq", 32'(bus.irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
